// File: rtl/dcache_param.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_param
//  Description : Parameterised write-back, write-allocate data cache.
//                1- or 2-way set associative with one LRU bit per set.
//                A miss writes back a dirty victim word by word, then fills
//                the block word by word. halt walks every line, writes back
//                the dirty ones and then parks in DONE with flushed high.
//
//  Parameters  : WAYS        - associativity (1 or 2)
//                SETS        - sets per way (power of 2, >= 2)
//                BLOCK_WORDS - 32-bit words per block (1, 2 or 4)
//
//  Ports       : CLK, RST        clock / synchronous active-high reset
//                dmemREN/WEN     datapath read/write request (both = write)
//                dmemaddr        datapath byte address ([1:0] ignored)
//                dmemstore       datapath write data
//                halt            request flush of dirty lines
//                dhit            request satisfied this cycle
//                dmemload        read data for a read hit
//                flushed         flush complete
//                dREN/dWEN       memory word read / write request
//                daddr, dstore   memory word address / write data
//                dwait           memory busy (transfer done when low)
//                dload           memory read data
//                hitcount        dhit cycles since reset (wraps)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_param #(
    parameter int WAYS        = 2,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic [31:0] hitcount
);

    localparam int c_OFF_W = $clog2(BLOCK_WORDS);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 30 - c_OFF_W - c_IDX_W;
    // Word counter keeps at least one bit so single-word blocks stay legal.
    localparam int c_CNT_W = (c_OFF_W == 0) ? 1 : c_OFF_W;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_WB    = 3'd1;
    localparam logic [2:0] c_S_FILL  = 3'd2;
    localparam logic [2:0] c_S_FLUSH = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic               r_valid [WAYS][SETS];
    logic               r_dirty [WAYS][SETS];
    logic [c_TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [31:0]        r_data  [WAYS][SETS][BLOCK_WORDS];
    // Index of the least recently used way in each set.
    logic               r_lru   [SETS];

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hitcount;

    // Miss context captured in IDLE so the WB/FILL sequence stays coherent
    // even if the datapath changes its request meanwhile.
    logic               r_vway;
    logic [c_IDX_W-1:0] r_fidx;
    logic [c_TAG_W-1:0] r_ftag;

    // Flush scan position.
    logic               r_fway;
    logic [c_IDX_W-1:0] r_fset;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]        w_word;
    logic [c_CNT_W-1:0] w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_unused;

    assign w_word   = dmemaddr[31:2];
    assign w_off    = c_CNT_W'(w_word & 30'(BLOCK_WORDS - 1));
    assign w_idx    = c_IDX_W'(w_word >> c_OFF_W);
    assign w_tag    = c_TAG_W'(w_word >> (c_OFF_W + c_IDX_W));
    // Byte-lane bits are intentionally ignored.
    assign w_unused = &{1'b0, dmemaddr[1:0]};

    function automatic logic [31:0] f_addr(
        input logic [c_TAG_W-1:0] tag,
        input logic [c_IDX_W-1:0] idx,
        input logic [c_CNT_W-1:0] cnt
    );
        logic [29:0] w;
        w = (30'(tag) << (c_OFF_W + c_IDX_W)) | (30'(idx) << c_OFF_W) | 30'(cnt);
        return {w, 2'b00};
    endfunction

    // ------------------------------------------------------------------
    // Lookup and victim selection
    // ------------------------------------------------------------------
    logic w_hit;
    logic w_hway;
    logic w_vway;
    logic w_vdirty;
    logic w_req;
    logic w_last;
    logic w_fl_dirty;
    logic w_scan_end;

    always_comb begin
        w_hit  = 1'b0;
        w_hway = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit  = 1'b1;
                w_hway = 1'(w);
            end
        end
    end

    // Invalid way first (way 0 preferred), otherwise the LRU way.
    always_comb begin
        w_vway = 1'b0;
        if (WAYS > 1) begin
            if (!r_valid[0][w_idx])
                w_vway = 1'b0;
            else if (!r_valid[WAYS-1][w_idx])
                w_vway = 1'b1;
            else
                w_vway = r_lru[w_idx];
        end
    end

    assign w_vdirty   = r_valid[w_vway][w_idx] && r_dirty[w_vway][w_idx];
    assign w_req      = dmemREN | dmemWEN;
    assign w_last     = (r_cnt == c_CNT_W'(BLOCK_WORDS - 1));
    assign w_fl_dirty = r_valid[r_fway][r_fset] && r_dirty[r_fway][r_fset];
    assign w_scan_end = (r_fset == c_IDX_W'(SETS - 1)) && (r_fway == 1'(WAYS - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= c_S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        dhit        = 1'b0;
        dmemload    = 32'd0;
        flushed     = 1'b0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = 32'd0;
        dstore      = 32'd0;
        case (r_state)
            c_S_IDLE: begin
                if (halt) begin
                    w_state_nxt = c_S_FLUSH;
                end else if (w_req) begin
                    if (w_hit) begin
                        dhit = 1'b1;
                        if (!dmemWEN)
                            dmemload = r_data[w_hway][w_idx][w_off];
                    end else begin
                        w_state_nxt = w_vdirty ? c_S_WB : c_S_FILL;
                    end
                end
            end
            c_S_WB: begin
                dWEN   = 1'b1;
                daddr  = f_addr(r_tag[r_vway][r_fidx], r_fidx, r_cnt);
                dstore = r_data[r_vway][r_fidx][r_cnt];
                if (!dwait && w_last)
                    w_state_nxt = c_S_FILL;
            end
            c_S_FILL: begin
                dREN  = 1'b1;
                daddr = f_addr(r_ftag, r_fidx, r_cnt);
                if (!dwait && w_last)
                    w_state_nxt = c_S_IDLE;
            end
            c_S_FLUSH: begin
                if (w_fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = f_addr(r_tag[r_fway][r_fset], r_fset, r_cnt);
                    dstore = r_data[r_fway][r_fset][r_cnt];
                    if (!dwait && w_last && w_scan_end)
                        w_state_nxt = c_S_DONE;
                end else if (w_scan_end) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                flushed = 1'b1;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line state, counters and miss/flush bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_tag[w][s]   <= '0;
                end
            end
            for (int s = 0; s < SETS; s++)
                r_lru[s] <= 1'b0;
            r_cnt      <= '0;
            r_hitcount <= 32'd0;
            r_vway     <= 1'b0;
            r_fidx     <= '0;
            r_ftag     <= '0;
            r_fway     <= 1'b0;
            r_fset     <= '0;
        end else begin
            if (dhit)
                r_hitcount <= r_hitcount + 32'd1;
            case (r_state)
                c_S_IDLE: begin
                    if (halt) begin
                        r_fway <= 1'b0;
                        r_fset <= '0;
                        r_cnt  <= '0;
                    end else if (w_req) begin
                        if (w_hit) begin
                            // The way not just used becomes the LRU way.
                            r_lru[w_idx] <= ~w_hway;
                            if (dmemWEN)
                                r_dirty[w_hway][w_idx] <= 1'b1;
                        end else begin
                            r_vway <= w_vway;
                            r_fidx <= w_idx;
                            r_ftag <= w_tag;
                            r_cnt  <= '0;
                        end
                    end
                end
                c_S_WB: begin
                    if (!dwait) begin
                        if (w_last) begin
                            r_cnt                  <= '0;
                            r_dirty[r_vway][r_fidx] <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_S_FILL: begin
                    if (!dwait) begin
                        if (w_last) begin
                            r_cnt                   <= '0;
                            r_valid[r_vway][r_fidx] <= 1'b1;
                            r_dirty[r_vway][r_fidx] <= 1'b0;
                            r_tag[r_vway][r_fidx]   <= r_ftag;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_S_FLUSH: begin
                    if (w_fl_dirty) begin
                        if (!dwait) begin
                            if (w_last) begin
                                r_cnt                   <= '0;
                                r_dirty[r_fway][r_fset] <= 1'b0;
                                if (r_fset == c_IDX_W'(SETS - 1)) begin
                                    r_fset <= '0;
                                    r_fway <= 1'b1;
                                end else begin
                                    r_fset <= r_fset + 1'b1;
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end else begin
                        if (r_fset == c_IDX_W'(SETS - 1)) begin
                            r_fset <= '0;
                            r_fway <= 1'b1;
                        end else begin
                            r_fset <= r_fset + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data array (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (dhit && dmemWEN)
                r_data[w_hway][w_idx][w_off] <= dmemstore;
            if ((r_state == c_S_FILL) && !dwait)
                r_data[r_vway][r_fidx][r_cnt] <= dload;
        end
    end

    assign hitcount = r_hitcount;

endmodule
`default_nettype wire

// File: tb/tb_dcache_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_param
//  Description : Self-checking bench for dcache_param. A transparent-memory
//                reference (latest written value per word) plus a per-set
//                recency model predicts read data and every memory transfer;
//                monitors compare what the DUT presents against queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_param;

    localparam int WAYS        = 2;
    localparam int SETS        = 8;
    localparam int BLOCK_WORDS = 2;
    localparam int c_BLK_BYTES = BLOCK_WORDS * 4;

    logic        CLK;
    logic        RST;
    logic        dmemREN, dmemWEN, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore, hitcount;

    dcache_param #(.WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS)) u_dut (
        .CLK(CLK), .RST(RST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .hitcount(hitcount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } item_t;
    item_t resp_q[$];
    item_t bus_q[$];

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] gold [logic [31:0]];

    bit          m_vld   [WAYS][SETS];
    bit          m_dirty [WAYS][SETS];
    logic [31:0] m_blk   [WAYS][SETS];
    longint      m_ts    [WAYS][SETS];
    longint      now_ts = 0;

    int wait_mode = 1;  // 0 random, 1 never busy, 2 always busy
    int hits_seen = 0;
    item_t mon_r;
    item_t bus_x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] initval(input logic [31:0] a);
        if (a == 32'h0) return 32'hA0;
        if (a == 32'h4) return 32'hA1;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return initval(a);
    endfunction

    function automatic logic [31:0] goldval(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return initval(a);
    endfunction

    // Predict one request: transfers it causes and the response it gets.
    function automatic void model_access(input logic [31:0] addr, input bit wr, input logic [31:0] data);
        logic [31:0] a, blk, wa;
        int s, hw, v;
        item_t it;
        a   = addr & ~32'h3;
        blk = a / c_BLK_BYTES;
        s   = int'(blk % SETS);
        hw  = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_vld[w][s] && m_blk[w][s] == blk) hw = w;
        if (hw < 0) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_vld[w][s]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++)
                    if (m_ts[w][s] < m_ts[v][s]) v = w;
            end
            if (m_vld[v][s] && m_dirty[v][s]) begin
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    wa = m_blk[v][s] * c_BLK_BYTES + 32'(i * 4);
                    it.wr = 1'b1; it.addr = wa; it.data = goldval(wa);
                    bus_q.push_back(it);
                end
            end
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                it.wr = 1'b0; it.addr = blk * c_BLK_BYTES + 32'(i * 4); it.data = 32'h0;
                bus_q.push_back(it);
            end
            m_vld[v][s] = 1'b1; m_dirty[v][s] = 1'b0; m_blk[v][s] = blk;
            hw = v;
        end
        now_ts++;
        m_ts[hw][s] = now_ts;
        it.addr = a;
        if (wr) begin
            m_dirty[hw][s] = 1'b1;
            gold[a] = data;
            it.wr = 1'b1; it.data = data;
        end else begin
            it.wr = 1'b0; it.data = goldval(a);
        end
        resp_q.push_back(it);
    endfunction

    function automatic void model_flush();
        item_t it;
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                if (m_vld[w][s] && m_dirty[w][s]) begin
                    for (int i = 0; i < BLOCK_WORDS; i++) begin
                        it.wr = 1'b1; it.addr = m_blk[w][s] * c_BLK_BYTES + 32'(i * 4);
                        it.data = goldval(it.addr);
                        bus_q.push_back(it);
                    end
                    m_dirty[w][s] = 1'b0;
                end
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_vld[w][s] = 1'b0; m_dirty[w][s] = 1'b0; m_ts[w][s] = 0;
            end
    endfunction

    // Memory side: busy pattern and read data.
    always @(posedge CLK) begin
        #1;
        case (wait_mode)
            1:       dwait = 1'b0;
            2:       dwait = 1'b1;
            default: dwait = ($urandom_range(0, 3) == 0);
        endcase
        dload = memval(daddr);
    end

    // Bus monitor.
    always @(negedge CLK) begin
        if (!RST) begin
            if (dREN || dWEN)
                check("bus_excl", {31'd0, dREN & dWEN}, 32'd0);
            if ((dREN || dWEN) && !dwait) begin
                if (bus_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL bus_unexpected: got dREN=%b dWEN=%b daddr=%h required no transfer", dREN, dWEN, daddr);
                end else begin
                    bus_x = bus_q.pop_front();
                    check("bus_kind", {31'd0, dWEN}, {31'd0, bus_x.wr});
                    check("bus_addr", daddr, bus_x.addr);
                    if (bus_x.wr) check("bus_wdata", dstore, bus_x.data);
                end
                if (dWEN) mem[daddr] = dstore;
            end
        end
    end

    // Response monitor.
    always @(negedge CLK) begin
        if (RST) begin
            hits_seen = 0;
        end else if (dhit) begin
            check("hitcount", hitcount, 32'(hits_seen));
            hits_seen++;
            if (resp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dhit_unexpected: got dhit=1 addr=%h required dhit=0", dmemaddr);
            end else begin
                mon_r = resp_q.pop_front();
                if (!mon_r.wr) check("rdata", dmemload, mon_r.data);
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input bit wr, input logic [31:0] data);
        int  n;
        bit  done;
        model_access(addr, wr, data);
        @(posedge CLK); #1;
        dmemaddr  = addr;
        dmemstore = data;
        dmemWEN   = wr;
        dmemREN   = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (dhit) done = 1'b1;
            else begin
                n++;
                if (n > 200) begin
                    n_vec++; n_err++;
                    $display("FAIL req_timeout: addr %h got no dhit required dhit=1", addr);
                    done = 1'b1;
                end
            end
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dhit"},     {31'd0, dhit},    32'd0);
        check({tag, "_dREN"},     {31'd0, dREN},    32'd0);
        check({tag, "_dWEN"},     {31'd0, dWEN},    32'd0);
        check({tag, "_flushed"},  {31'd0, flushed}, 32'd0);
        check({tag, "_daddr"},    daddr,            32'd0);
        check({tag, "_dstore"},   dstore,           32'd0);
        check({tag, "_dmemload"}, dmemload,         32'd0);
        check({tag, "_hitcount"}, hitcount,         32'd0);
    endtask

    initial begin
        int n;
        RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dmemaddr = 32'd0; dmemstore = 32'd0;
        model_reset();

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // Directed sequence on index 0 with an always-ready memory.
        wait_mode = 1;
        do_req(32'h0, 1'b0, 32'h0);
        check("hitcount_after_cold", hitcount, 32'd1);
        do_req(32'h4, 1'b0, 32'h0);
        do_req(32'h4, 1'b1, 32'hD4D4_D4D4);
        do_req(32'h4, 1'b0, 32'h0);
        do_req(32'h40, 1'b0, 32'h0);
        do_req(32'h40, 1'b1, 32'h4040_1234);
        do_req(32'h80, 1'b0, 32'h0);
        check("directed_bus_drained", 32'(bus_q.size()), 32'd0);

        // Randomised traffic with a randomly busy memory.
        wait_mode = 0;
        for (int k = 0; k < 300; k++)
            do_req(32'($urandom_range(0, 32'h1FF)), ($urandom_range(0, 2) == 0), $urandom);

        // Flush: halt overrides a simultaneous request.
        model_flush();
        @(posedge CLK); #1;
        halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h4;
        n = 0;
        while (!flushed && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("flushed_reached", {31'd0, flushed}, 32'd1);
        check("flush_bus_drained", 32'(bus_q.size()), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("done_flushed", {31'd0, flushed}, 32'd1);
            check("done_dhit",    {31'd0, dhit},    32'd0);
            check("done_dREN",    {31'd0, dREN},    32'd0);
        end
        foreach (gold[a]) check("mem_after_flush", memval(a), gold[a]);

        // Reset out of DONE.
        @(posedge CLK); #1;
        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset2");
        @(posedge CLK); #1;
        RST = 1'b0;

        // Reset aborts a stalled fill.
        wait_mode = 2;
        @(posedge CLK); #1;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        @(posedge CLK);
        @(negedge CLK);
        check("abort_dREN_before", {31'd0, dREN}, 32'd1);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1; dmemREN = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            check("abort_dREN_after", {31'd0, dREN}, 32'd0);
            check("abort_daddr_after", daddr, 32'd0);
        end
        wait_mode = 0;
        do_req(32'h100, 1'b0, 32'h0);
        do_req(32'h104, 1'b1, 32'hCAFE_F00D);
        do_req(32'h104, 1'b0, 32'h0);

        repeat (3) @(posedge CLK);
        check("final_resp_drained", 32'(resp_q.size()), 32'd0);
        check("final_bus_drained", 32'(bus_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: got no end of test required completion by %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
